hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Produces the 'hazard' stall input of the decode stage. It is the other end of that stage's
//  source-register interface (src1, src2, two_src) and its decoded control outputs.
//  A 2-entry scoreboard records the in-flight EXE and MEM destinations. The unit compares the
//  decoding instruction's sources against them and raises a RAW stall.
//  It sits beside ID, between IF/ID and ID/EXE. Its inputs are cache freeze and branch flush.
// PARAMETERS
//  FORWARD_EN  0   0: stall on any EXE/MEM dest match. 1: stall only on load-use (EXE load).
//  REG_W       4   register index width
//  CNT_W       16  stall-counter width
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  id_valid     in   1      IF/ID holds a real instruction
//  id_src1      in   REG_W  first source (Rn)
//  id_src2      in   REG_W  second source (Rm, or Rd for stores)
//  id_two_src   in   1      id_src2 is really read
//  id_wb_en     in   1      decoded WB enable, before hazard gating
//  id_mem_r_en  in   1      decoded load, before hazard gating
//  id_dest      in   REG_W  decoded destination (Rd)
//  freeze       in   1      memory/cache stall; whole pipeline holds
//  flush        in   1      branch taken; IF/ID contents discarded
//  hazard       out  1      stall IF and IF/ID, insert bubble into ID/EXE
//  exe_valid    out  1      scoreboard EXE entry writes back
//  exe_dest     out  REG_W  EXE entry destination
//  mem_valid    out  1      MEM entry writes back
//  mem_dest     out  REG_W  MEM entry destination
//  stall_count  out  CNT_W  cycles stalled by hazard
// BEHAVIOUR
//  - Reset: both entries become {valid=0, dest=0, load=0}. Outputs: hazard=0, exe_valid=0,
//    exe_dest=0, mem_valid=0, mem_dest=0, stall_count=0.
//  - Entry = {valid, dest, load}. Nothing is tracked for WB: the register file writes on the
//    opposite clock edge, so a WB-stage writer never causes a hazard.
//  - Source matching:
//    - m1 = src1 matches an entry.
//    - m2 = two_src and src2 matches an entry.
//    - Only entries with valid=1 can match.
//  - hazard is combinational with zero latency: id_valid & ~flush & H.
//    - FORWARD_EN=0: H = (m1|m2) against EXE or MEM.
//    - FORWARD_EN=1: H = (m1|m2) against EXE with exe.load=1 only.
//  - Advance rule, evaluated each rising edge with priority rst > freeze > normal:
//    - freeze=1: both entries hold and flush is ignored. The pipeline controller holds flush
//      until freeze drops.
//    - Normal: MEM <= EXE.
//    - Normal: EXE <= {id_wb_en, id_dest, id_mem_r_en} when issue = id_valid & ~hazard & ~flush.
//    - Normal: otherwise EXE <= bubble (valid=0, dest=0, load=0).
//  - Issued instruction with id_wb_en=0 (store, branch, CMP/TST): EXE.valid=0 and no tracking.
//  - Same dest in EXE and MEM: both are tracked and the stall lasts until both retire.
//  - Stall length after a back-to-back RAW:
//    - FORWARD_EN=0: 2 cycles if the producer is in EXE, 1 cycle if it is in MEM.
//    - FORWARD_EN=1: exactly 1 cycle for load-use.
//  - Any register index, including r15, is compared; no special casing.
//  - stall_count increments when hazard & ~freeze and saturates at all-ones. It is cleared
//    only by rst.
//  - Reset mid-stall: the scoreboard clears, so hazard drops the same cycle reset is applied
//    and stays 0 until a new issue.
// STRUCTURE
//  - Shared package: ENTRY_W, reg-index width, and the bubble constant.
//  - One natural sub-module, sb_entry_reg: one scoreboard stage with hold, load and clear.
//    It is instantiated twice. Compare logic and counter live at top level.
// TESTING
//  1. rst=1 two cycles, then idle -> hazard=0, exe_valid=0, mem_valid=0, stall_count=0.
//  2. FORWARD_EN=0: ADD r1 issues, then SUB src1=r1 ->
//     - hazard=1 two cycles, then issues cycle 3;
//     - stall_count=2.
//  3. FORWARD_EN=1: LDR dest=r2 (mem_r_en=1), then ADD src2=r2, two_src=1 ->
//     - hazard=1 exactly 1 cycle;
//     - the same sequence with an ADD producer gives hazard=0.
//  4. MOV dest=r3, then instruction src2=r3 with two_src=0 -> hazard=0, no stall.
//  5. Hazard active with freeze=1 for 5 cycles ->
//     - exe/mem outputs constant;
//     - hazard stays 1;
//     - stall_count unchanged;
//     - stall resolves normally after freeze drops.
//  6. Producer ADD r4 with flush=1 on its ID cycle, then consumer src1=r4 -> hazard=0.
//     The flushed instruction never enters EXE.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the decode-stage RAW hazard scoreboard.
package hazard_scoreboard_unit_pkg;

  // Default register-index and stall-counter widths.
  localparam int unsigned REG_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  // Scoreboard entry layout, MSB to LSB: {valid, dest[REG_W-1:0], load}.
  localparam int unsigned ENTRY_W = REG_W_DEF + 2;

  // Bit positions of the single-bit fields in an entry of a given width.
  localparam int unsigned ENTRY_LOAD_BIT = 0;

  // A bubble is an empty slot: not valid, dest 0, not a load.
  localparam logic [ENTRY_W-1:0] SB_BUBBLE = '0;

  // Per-cycle action of one scoreboard stage.
  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_LOAD  = 2'd1,
    SB_CLEAR = 2'd2
  } sb_op_e;

  // Entry width for a given register-index width.
  function automatic int unsigned entry_width(input int unsigned reg_w);
    return reg_w + 2;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_sb_entry_reg.sv
// One scoreboard stage: holds a {valid, dest, load} entry, with hold, load and clear.
module sb_entry_reg
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  sb_op_e                        op,
  input  logic [entry_width(REG_W)-1:0] load_val,
  output logic [entry_width(REG_W)-1:0] entry
);

  localparam int unsigned EW = entry_width(REG_W);

  logic [EW-1:0] entry_d;
  logic [EW-1:0] entry_q;

  // Next entry: keep, take the new value, or drop to an all-zero bubble.
  always_comb begin
    entry_d = entry_q;
    case (op)
      SB_HOLD:  entry_d = entry_q;
      SB_LOAD:  entry_d = load_val;
      SB_CLEAR: entry_d = '0;
      default:  entry_d = entry_q;
    endcase
  end

  // Entry register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage RAW hazard detector backed by a 2-entry (EXE, MEM) destination scoreboard.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter bit          FORWARD_EN = 1'b0,
  parameter int unsigned REG_W      = REG_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             freeze,
  input  logic             flush,
  output logic             hazard,
  output logic             exe_valid,
  output logic [REG_W-1:0] exe_dest,
  output logic             mem_valid,
  output logic [REG_W-1:0] mem_dest,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned EW = entry_width(REG_W);

  logic [EW-1:0] exe_entry;
  logic [EW-1:0] mem_entry;
  logic [EW-1:0] id_entry;
  sb_op_e        exe_op;
  sb_op_e        mem_op;

  logic          exe_load;
  logic          m_exe;
  logic          m_mem;
  logic          raw_hit;
  logic          issue;

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Entry field unpacking.
  assign exe_valid = exe_entry[EW-1];
  assign exe_dest  = exe_entry[EW-2:1];
  assign exe_load  = exe_entry[ENTRY_LOAD_BIT];
  assign mem_valid = mem_entry[EW-1];
  assign mem_dest  = mem_entry[EW-2:1];

  assign id_entry  = {id_wb_en, id_dest, id_mem_r_en};

  // Source comparison against each valid scoreboard entry.
  always_comb begin
    m_exe = exe_valid &
            ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
    m_mem = mem_valid &
            ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
  end

  // With forwarding only a load still in EXE cannot be bypassed.
  always_comb begin
    if (FORWARD_EN) begin
      raw_hit = m_exe & exe_load;
    end else begin
      raw_hit = m_exe | m_mem;
    end
  end

  // Reset is gated in so a stall drops in the same cycle reset is applied,
  // before the synchronous clear of the entries takes effect.
  always_comb begin
    hazard = ~rst & id_valid & ~flush & raw_hit;
    issue  = id_valid & ~hazard & ~flush;
  end

  // Stage control: freeze holds both entries; otherwise MEM takes EXE and
  // EXE takes the issuing instruction or a bubble.
  always_comb begin
    exe_op = SB_HOLD;
    mem_op = SB_HOLD;
    if (!freeze) begin
      mem_op = SB_LOAD;
      exe_op = issue ? SB_LOAD : SB_CLEAR;
    end
  end

  sb_entry_reg #(.REG_W(REG_W)) u_exe_entry (
    .clk      (clk),
    .rst      (rst),
    .op       (exe_op),
    .load_val (id_entry),
    .entry    (exe_entry)
  );

  sb_entry_reg #(.REG_W(REG_W)) u_mem_entry (
    .clk      (clk),
    .rst      (rst),
    .op       (mem_op),
    .load_val (exe_entry),
    .entry    (mem_entry)
  );

  // Saturating count of cycles spent stalling while the pipeline advances.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !freeze && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: one instance without forwarding
// (16-bit counter) and one with forwarding (2-bit counter to reach saturation).
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_src1 = '0;
  logic [3:0] id_src2 = '0;
  logic       id_two_src = 1'b0;
  logic       id_wb_en = 1'b0;
  logic       id_mem_r_en = 1'b0;
  logic [3:0] id_dest = '0;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;

  logic        hazard_0, exe_valid_0, mem_valid_0;
  logic [3:0]  exe_dest_0, mem_dest_0;
  logic [15:0] stall_count_0;
  logic        hazard_1, exe_valid_1, mem_valid_1;
  logic [3:0]  exe_dest_1, mem_dest_1;
  logic [1:0]  stall_count_1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic c0;
    logic e0;
    logic c1;
    logic e1;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.FORWARD_EN(1'b0), .REG_W(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .freeze(freeze), .flush(flush), .hazard(hazard_0),
    .exe_valid(exe_valid_0), .exe_dest(exe_dest_0), .mem_valid(mem_valid_0),
    .mem_dest(mem_dest_0), .stall_count(stall_count_0)
  );

  hazard_scoreboard_unit #(.FORWARD_EN(1'b1), .REG_W(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .freeze(freeze), .flush(flush), .hazard(hazard_1),
    .exe_valid(exe_valid_1), .exe_dest(exe_dest_1), .mem_valid(mem_valid_1),
    .mem_dest(mem_dest_1), .stall_count(stall_count_1)
  );

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic ld,
                       input logic [3:0] d);
    id_valid    = v;
    id_src1     = s1;
    id_src2     = s2;
    id_two_src  = two;
    id_wb_en    = wb;
    id_mem_r_en = ld;
    id_dest     = d;
  endtask

  // Push the expected hazard for this cycle, compare at the falling edge,
  // then advance past the next rising edge.
  task automatic cyc(input logic c0, input logic e0, input logic c1, input logic e1,
                     input string tag);
    exp_t e;
    exp_q.push_back('{c0: c0, e0: e0, c1: c1, e1: e1});
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.c0) begin
      checks++;
      if (hazard_0 !== e.e0) begin
        errors++;
        $display("FAIL %s fwd0 hazard: got %b expected %b", tag, hazard_0, e.e0);
      end
    end
    if (e.c1) begin
      checks++;
      if (hazard_1 !== e.e1) begin
        errors++;
        $display("FAIL %s fwd1 hazard: got %b expected %b", tag, hazard_1, e.e1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "reset_idle");
    checks++;
    if ({exe_valid_0, exe_dest_0, mem_valid_0, mem_dest_0, stall_count_0} !== 26'd0) begin
      errors++;
      $display("FAIL reset_fwd0: got ev=%b ed=%0d mv=%b md=%0d cnt=%0d expected all 0",
               exe_valid_0, exe_dest_0, mem_valid_0, mem_dest_0, stall_count_0);
    end
    checks++;
    if ({exe_valid_1, exe_dest_1, mem_valid_1, mem_dest_1, stall_count_1} !== 12'd0) begin
      errors++;
      $display("FAIL reset_fwd1: got ev=%b ed=%0d mv=%b md=%0d cnt=%0d expected all 0",
               exe_valid_1, exe_dest_1, mem_valid_1, mem_dest_1, stall_count_1);
    end
  endtask

  task automatic test_raw_no_forward();
    do_reset();
    drive(1'b1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 4'd1);   // ADD r1
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "raw_producer");
    checks++;
    if (exe_valid_0 !== 1'b1 || exe_dest_0 !== 4'd1) begin
      errors++;
      $display("FAIL raw_exe_entry: got valid=%b dest=%0d expected valid=1 dest=1",
               exe_valid_0, exe_dest_0);
    end
    drive(1'b1, 4'd1, 4'd7, 1'b1, 1'b1, 1'b0, 4'd8);   // SUB src1=r1
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "raw_stall1");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "raw_stall2");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "raw_issue");
    checks++;
    if (exe_valid_0 !== 1'b1 || exe_dest_0 !== 4'd8) begin
      errors++;
      $display("FAIL raw_consumer_issued: got valid=%b dest=%0d expected valid=1 dest=8",
               exe_valid_0, exe_dest_0);
    end
    checks++;
    if (stall_count_0 !== 16'd2) begin
      errors++;
      $display("FAIL raw_stall_count: got %0d expected 2", stall_count_0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 4'd9, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2);   // LDR r2
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "lu_load");
    drive(1'b1, 4'd10, 4'd2, 1'b1, 1'b1, 1'b0, 4'd11); // ADD src2=r2
    cyc(1'b1, 1'b1, 1'b1, 1'b1, "lu_stall1");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "lu_stall2");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "lu_issue");
    checks++;
    if (stall_count_1 !== 2'd1) begin
      errors++;
      $display("FAIL lu_stall_count: got %0d expected 1", stall_count_1);
    end
    do_reset();
    drive(1'b1, 4'd9, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2);   // ADD r2 producer
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "alu_producer");
    drive(1'b1, 4'd10, 4'd2, 1'b1, 1'b1, 1'b0, 4'd11);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "alu_consumer");
  endtask

  task automatic test_two_src();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3);   // MOV r3
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "mov_producer");
    drive(1'b1, 4'd12, 4'd3, 1'b0, 1'b1, 1'b0, 4'd13); // src2=r3 not read
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "two_src_off");
    checks++;
    if (stall_count_0 !== 16'd0) begin
      errors++;
      $display("FAIL two_src_count: got %0d expected 0", stall_count_0);
    end
  endtask

  task automatic test_r15();
    do_reset();
    drive(1'b1, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 4'd15);  // writes r15
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "r15_producer");
    drive(1'b1, 4'd2, 4'd15, 1'b1, 1'b0, 1'b0, 4'd0);  // store reading r15
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "r15_consumer");
  endtask

  task automatic test_freeze();
    logic [9:0] snap;
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4);   // ADD r4
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "frz_producer");
    drive(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5);
    freeze = 1'b1;
    snap = {exe_valid_0, exe_dest_0, mem_valid_0, mem_dest_0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "frz_hold");
      checks++;
      if ({exe_valid_0, exe_dest_0, mem_valid_0, mem_dest_0} !== snap ||
          stall_count_0 !== 16'd0) begin
        errors++;
        $display("FAIL frz_state: got entries=%h cnt=%0d expected entries=%h cnt=0",
                 {exe_valid_0, exe_dest_0, mem_valid_0, mem_dest_0}, stall_count_0, snap);
      end
    end
    freeze = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "frz_release1");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "frz_release2");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "frz_issue");
    checks++;
    if (stall_count_0 !== 16'd2) begin
      errors++;
      $display("FAIL frz_count: got %0d expected 2", stall_count_0);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4);   // ADD r4, flushed
    flush = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "flush_producer");
    flush = 1'b0;
    checks++;
    if (exe_valid_0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_exe_valid: got %b expected 0", exe_valid_0);
    end
    drive(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "flush_consumer");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "rms_producer");
    drive(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, "rms_stall");
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "rms_reset_cycle");
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "rms_after_reset");
    checks++;
    if (exe_valid_0 !== 1'b1 || exe_dest_0 !== 4'd7 || stall_count_0 !== 16'd0) begin
      errors++;
      $display("FAIL rms_state: got valid=%b dest=%0d cnt=%0d expected valid=1 dest=7 cnt=0",
               exe_valid_0, exe_dest_0, stall_count_0);
    end
  endtask

  task automatic test_back_to_back_saturate();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2); // LDR r2
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "sat_load");
      drive(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 4'd11);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, "sat_stall");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "sat_issue");
      checks++;
      if (stall_count_1 !== 2'((i > 3) ? 3 : i)) begin
        errors++;
        $display("FAIL sat_count iter %0d: got %0d expected %0d", i, stall_count_1,
                 (i > 3) ? 3 : i);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_raw_no_forward();
    test_load_use();
    test_two_src();
    test_r15();
    test_freeze();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
